// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREG_DEF  = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;

    function automatic int addr_width(input int nreg);
        return (nreg <= 2) ? 1 : $clog2(nreg);
    endfunction

    // Counter must hold the value NREG itself, hence the +1.
    function automatic int cnt_width(input int nreg);
        return $clog2(nreg + 1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit tracking for outstanding producers: reservation accept, per-port
// busy lookup and a registered count of busy registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF,
    parameter int NWR  = NWR_DEF,
    localparam int AW  = addr_width(NREG),
    localparam int CW  = cnt_width(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic              iss_ready,
    output logic [NRD-1:0]    rd_busy,
    output logic [CW-1:0]     busy_cnt
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] busy_next;
    logic [CW-1:0]   cnt_next;

    // Registers hit by any write this cycle; address 0 is never a target.
    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
        end
    end

    // A same-cycle write frees the register, so a new producer may claim it.
    always_comb begin
        iss_ready = iss_en && (iss_addr != '0) &&
                    (!busy[iss_addr] || wr_hit[iss_addr]);
        busy_next = busy & ~wr_hit;
        if (iss_ready)
            busy_next[iss_addr] = 1'b1;
    end

    always_comb begin
        cnt_next = '0;
        for (int k = 0; k < NREG; k++)
            cnt_next = cnt_next + CW'(busy_next[k]);
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = (rd_addr[i*AW +: AW] != '0) &&
                         busy[rd_addr[i*AW +: AW]] &&
                         !wr_hit[rd_addr[i*AW +: AW]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with write-through bypass and a busy-bit
// scoreboard for destination reservation.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF,
    localparam int AW   = addr_width(NREG),
    localparam int CW   = cnt_width(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_data,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic                 iss_ready,
    output logic [CW-1:0]        busy_cnt
);

    logic [WIDTH-1:0] regs [NREG];

    // Ports are visited in ascending order so the highest-index port lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++)
                regs[k] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*WIDTH +: WIDTH];
            end
        end
    end

    // Bypass uses the same port priority as storage.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*WIDTH +: WIDTH] = regs[rd_addr[i*AW +: AW]];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
                    rd_data[i*WIDTH +: WIDTH] = wr_data[j*WIDTH +: WIDTH];
            end
            if (rd_addr[i*AW +: AW] == '0)
                rd_data[i*WIDTH +: WIDTH] = '0;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .rd_busy   (rd_busy),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an array-based reference model.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic [5:0]  busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    logic [31:0] model_regs [32];
    bit          model_busy [32];
    int          model_cnt;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] wa(input int j);
        return wr_addr[j*5 +: 5];
    endfunction

    function automatic logic [31:0] wd(input int j);
        return wr_data[j*32 +: 32];
    endfunction

    function automatic bit anyWrite(input logic [4:0] a);
        bit hit = 0;
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wa(j) == a && a != 0) hit = 1;
        return hit;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] a);
        logic [31:0] r;
        if (a == 0) return 32'h0;
        r = model_regs[a];
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wa(j) == a) r = wd(j);
        return r;
    endfunction

    function automatic bit expBusy(input logic [4:0] a);
        return (a != 0) && model_busy[a] && !anyWrite(a);
    endfunction

    function automatic bit expIss();
        return iss_en && (iss_addr != 0) && (!model_busy[iss_addr] || anyWrite(iss_addr));
    endfunction

    // Predict the state that the next rising edge will produce.
    task automatic modelStep();
        bit acc;
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                model_regs[k] = 32'h0;
                model_busy[k] = 0;
            end
        end else begin
            acc = expIss();
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wa(j) != 0) begin
                    model_regs[wa(j)] = wd(j);
                    model_busy[wa(j)] = 0;
                end
            end
            if (acc) model_busy[iss_addr] = 1;
        end
        model_cnt = 0;
        for (int k = 0; k < 32; k++)
            model_cnt += int'(model_busy[k]);
    endtask

    // Inputs change just after posedge, so at negedge they are the values the next edge will see.
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("model rd_data[%0d] addr %0d", i, rd_addr[i*5 +: 5]),
                            rd_data[i*32 +: 32], expRead(rd_addr[i*5 +: 5]));
                checkOutput($sformatf("model rd_busy[%0d] addr %0d", i, rd_addr[i*5 +: 5]),
                            32'(rd_busy[i]), 32'(expBusy(rd_addr[i*5 +: 5])));
            end
            checkOutput("model iss_ready", 32'(iss_ready), 32'(expIss()));
            checkOutput("model busy_cnt", 32'(busy_cnt), 32'(model_cnt));
        end
        modelStep();
    end

    task automatic applyStimulus(input logic r, input logic [1:0] we,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic ie, input logic [4:0] ia);
        @(posedge clk);
        #1;
        rst      = r;
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        rd_addr  = {ra1, ra0};
        iss_en   = ie;
        iss_addr = ia;
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, ra0, ra1, 0, 0);
    endtask

    task automatic sampleNow();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; iss_en = 0; iss_addr = 0;
        for (int k = 0; k < 32; k++) begin
            model_regs[k] = 32'h0;
            model_busy[k] = 0;
        end
        model_cnt = 0;
        repeat (3) @(posedge clk);
        check_en = 1;

        // Every address reads zero and idle after reset.
        for (int i = 0; i < 16; i++) begin
            idle(5'(i), 5'(i + 16));
            sampleNow();
            checkOutput("reset rd_data[0]", rd_data[31:0], 32'h0);
            checkOutput("reset rd_data[1]", rd_data[63:32], 32'h0);
            checkOutput("reset rd_busy", 32'(rd_busy), 32'h0);
            checkOutput("reset busy_cnt", 32'(busy_cnt), 32'h0);
        end

        // Write-through bypass and persistence; register 0 stays zero.
        applyStimulus(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0, 0);
        sampleNow();
        checkOutput("bypass addr5", rd_data[31:0], 32'hDEADBEEF);
        idle(5, 0);
        sampleNow();
        checkOutput("stored addr5", rd_data[31:0], 32'hDEADBEEF);
        applyStimulus(0, 2'b01, 0, 32'h1234, 0, 0, 5, 0, 0, 0);
        sampleNow();
        checkOutput("bypass addr0", rd_data[63:32], 32'h0);
        idle(0, 5);
        sampleNow();
        checkOutput("stored addr0", rd_data[31:0], 32'h0);
        checkOutput("addr5 kept", rd_data[63:32], 32'hDEADBEEF);

        // Same-address writes: port 1 wins.
        applyStimulus(0, 2'b11, 7, 32'h11, 7, 32'h22, 7, 7, 0, 0);
        sampleNow();
        checkOutput("collide bypass", rd_data[31:0], 32'h22);
        idle(7, 0);
        sampleNow();
        checkOutput("collide stored", rd_data[31:0], 32'h22);

        // Reservation, rejected re-reservation, then write plus re-reserve.
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 3, 0, 1, 3);
        sampleNow();
        checkOutput("reserve3 ready", 32'(iss_ready), 32'h1);
        checkOutput("reserve3 not yet busy", 32'(rd_busy[0]), 32'h0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 3, 0, 1, 3);
        sampleNow();
        checkOutput("busy_cnt after reserve", 32'(busy_cnt), 32'h1);
        checkOutput("rd_busy addr3", 32'(rd_busy[0]), 32'h1);
        checkOutput("re-reserve rejected", 32'(iss_ready), 32'h0);
        idle(3, 0);
        sampleNow();
        checkOutput("busy_cnt after reject", 32'(busy_cnt), 32'h1);
        applyStimulus(0, 2'b01, 3, 32'hABCD, 0, 0, 3, 0, 1, 3);
        sampleNow();
        checkOutput("write+reserve ready", 32'(iss_ready), 32'h1);
        checkOutput("rd_busy hidden by write", 32'(rd_busy[0]), 32'h0);
        checkOutput("write+reserve bypass", rd_data[31:0], 32'hABCD);
        idle(3, 0);
        sampleNow();
        checkOutput("busy_cnt new producer", 32'(busy_cnt), 32'h1);
        checkOutput("rd_busy new producer", 32'(rd_busy[0]), 32'h1);
        checkOutput("write+reserve stored", rd_data[31:0], 32'hABCD);

        // Fill the scoreboard, then reset partway through a second fill.
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 32; k++) begin
            applyStimulus(0, 2'b00, 0, 0, 0, 0, 5'(k), 0, 1, 5'(k));
            sampleNow();
            checkOutput("fill ready", 32'(iss_ready), 32'h1);
        end
        idle(31, 1);
        sampleNow();
        checkOutput("busy_cnt full", 32'(busy_cnt), 32'd31);
        checkOutput("rd_busy full", 32'(rd_busy), 32'h3);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 16; k++)
            applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 5'(k));
        applyStimulus(1, 2'b01, 9, 32'h55, 0, 0, 9, 16, 1, 16);
        sampleNow();
        checkOutput("busy_cnt before reset", 32'(busy_cnt), 32'd15);
        idle(9, 16);
        sampleNow();
        checkOutput("busy_cnt after reset", 32'(busy_cnt), 32'h0);
        checkOutput("rd_busy after reset", 32'(rd_busy), 32'h0);
        checkOutput("write discarded by reset", rd_data[31:0], 32'h0);

        // Randomized traffic with frequent address collisions.
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] a [5];
            for (int m = 0; m < 5; m++)
                a[m] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom),
                          a[0], $urandom, a[1], $urandom, a[2], a[3],
                          ($urandom_range(0, 2) != 0), a[4]);
        end
        idle(0, 0);
        sampleNow();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
